// File: rtl/isq.sv
// Instruction sequencer: fetches an opcode plus up to three operand bytes,
// then steps the microcode index through EXEC until the decoder ends the instruction.
module isq (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_data,
  input  logic       mem_valid,
  output logic       mem_req,
  output logic       pc_inc,
  input  logic [1:0] len,
  input  logic       pc_ini,
  input  logic       pc_lrc,
  output logic [7:0] insn,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic [2:0] is,
  output logic       exec
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    LEN       = 3'd2,
    FETCH_ARG = 3'd3,
    EXEC      = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] cnt;
  logic [1:0] cnt_next;
  logic [1:0] len_q;
  logic       accept;
  logic       exec_end;

  assign accept   = mem_req && mem_valid;
  assign cnt_next = cnt + 2'd1;
  assign exec_end = pc_ini || pc_lrc || (is == 3'd7);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      state_next = FETCH_OP;
      FETCH_OP:  if (accept) state_next = LEN;
      LEN:       state_next = (len == 2'd0) ? EXEC : FETCH_ARG;
      FETCH_ARG: if (accept && (cnt_next == len_q)) state_next = EXEC;
      EXEC:      if (exec_end) state_next = FETCH_OP;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    exec    = 1'b0;
    unique case (state)
      FETCH_OP:  mem_req = 1'b1;
      FETCH_ARG: mem_req = 1'b1;
      EXEC:      exec    = 1'b1;
      default: begin
        mem_req = 1'b0;
        exec    = 1'b0;
      end
    endcase
  end

  // Byte capture, operand counter and held operand count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      insn  <= 8'd0;
      d1    <= 8'd0;
      d2    <= 8'd0;
      d3    <= 8'd0;
      cnt   <= 2'd0;
      len_q <= 2'd0;
    end else begin
      if (state == FETCH_OP && accept) begin
        insn <= mem_data;
        d1   <= 8'd0;
        d2   <= 8'd0;
        d3   <= 8'd0;
        cnt  <= 2'd0;
      end
      if (state == LEN) begin
        len_q <= len;
      end
      if (state == FETCH_ARG && accept) begin
        unique case (cnt)
          2'd0:    d1 <= mem_data;
          2'd1:    d2 <= mem_data;
          2'd2:    d3 <= mem_data;
          default: d3 <= d3;
        endcase
        cnt <= cnt_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_inc <= 1'b0;
    end else begin
      pc_inc <= accept;
    end
  end

  // The step index only advances while staying in EXEC, so it is 0 on entry and everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is <= 3'd0;
    end else if (state == EXEC && state_next == EXEC) begin
      is <= is + 3'd1;
    end else begin
      is <= 3'd0;
    end
  end

endmodule
